secded_decoder_72_64: RTL

- Receive-side checker for the 72-bit SEC-DED channel; sits downstream of the fault injector, consuming the possibly-corrupted codeword.
- Corrects any single-bit error and flags any double-bit error.
- Delivers the 64-bit data word through a 2-stage valid/ready pipeline.
- Keeps saturating corrected-error (CE) and uncorrectable-error (UE) counters for campaign statistics.

---
 rtl/secded_decoder_72_64.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/secded_decoder_72_64.sv
// secded_decoder_72_64: SEC-DED (72,64) decoder with 2-stage valid/ready pipeline and saturating CE/UE counters.
// Define ECC_ERR_LOG_EN to add a sticky first-error log (log_valid/log_ue/log_syndrome/log_code).
module secded_decoder_72_64 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_ce,
  output logic             out_ue,
  output logic [7:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_count,
  output logic [CNT_W-1:0] ue_count
`ifdef ECC_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic             log_ue,
  output logic [7:0]       log_syndrome,
  output logic [71:0]      log_code
`endif
);
  function automatic logic [7:0] f_syn(input logic [71:0] c);
    logic [6:0] s;
    s = '0;
    for (int j = 1; j < 72; j++) if (c[j]) s ^= j[6:0];
    return {^c, s};
  endfunction

  // data occupies every non-power-of-two index in ascending order
  function automatic logic [63:0] f_data(input logic [71:0] c);
    logic [63:0] d;
    int k;
    d = '0;
    k = 0;
    for (int j = 1; j < 72; j++) begin
      if ((j & (j - 1)) != 0) begin
        d[k[5:0]] = c[j];
        k++;
      end
    end
    return d;
  endfunction

  logic             r_s1_valid, r_s1_p, r_s2_valid, r_ce, r_ue;
  logic [71:0]      r_s1_code;
  logic [6:0]       r_s1_s;
  logic [63:0]      r_data;
  logic [7:0]       r_syn;
  logic [CNT_W-1:0] r_ce_cnt, r_ue_cnt;
  logic             w_s2_load, w_s1_load, w_xfer, w_ce, w_ue, w_fix_en;
  logic [7:0]       w_syn;
  logic [71:0]      w_fix;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = !rst && w_s1_load;
  assign w_xfer    = r_s2_valid && out_ready;
  assign w_syn     = f_syn(in_code);
  assign w_ce      = r_s1_p && (r_s1_s < 7'd72);
  assign w_ue      = r_s1_p ? (r_s1_s >= 7'd72) : (r_s1_s != 7'd0);
  assign w_fix_en  = w_ce && (r_s1_s != 7'd0);
  assign w_fix     = r_s1_code ^ (w_fix_en ? (72'd1 << r_s1_s) : 72'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_s     <= '0;
      r_s1_p     <= 1'b0;
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_ce       <= 1'b0;
      r_ue       <= 1'b0;
      r_syn      <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        r_s1_code  <= in_code;
        r_s1_s     <= w_syn[6:0];
        r_s1_p     <= w_syn[7];
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        r_data     <= f_data(w_fix);
        r_ce       <= w_ce;
        r_ue       <= w_ue;
        r_syn      <= {r_s1_p, r_s1_s};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else begin
      if (w_xfer && r_ce && !(&r_ce_cnt)) r_ce_cnt <= r_ce_cnt + 1'b1;
      if (w_xfer && r_ue && !(&r_ue_cnt)) r_ue_cnt <= r_ue_cnt + 1'b1;
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_data     = r_data;
  assign out_ce       = r_ce;
  assign out_ue       = r_ue;
  assign out_syndrome = r_syn;
  assign ce_count     = r_ce_cnt;
  assign ue_count     = r_ue_cnt;

`ifdef ECC_ERR_LOG_EN
  logic        r_s2_code_vld, r_log_valid, r_log_ue;
  logic [71:0] r_s2_code, r_log_code;
  logic [7:0]  r_log_syn;
  assign r_s2_code_vld = r_s2_valid;
  always_ff @(posedge clk) begin
    if (rst) r_s2_code <= '0;
    else if (w_s2_load) r_s2_code <= r_s1_code;
  end
  // sticky: only the first erroneous transfer after rst/cnt_clr is kept
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_log_valid <= 1'b0;
      r_log_ue    <= 1'b0;
      r_log_syn   <= '0;
      r_log_code  <= '0;
    end else if (w_xfer && r_s2_code_vld && (r_ce || r_ue) && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_ue    <= r_ue;
      r_log_syn   <= r_syn;
      r_log_code  <= r_s2_code;
    end
  end
  assign log_valid    = r_log_valid;
  assign log_ue       = r_log_ue;
  assign log_syndrome = r_log_syn;
  assign log_code     = r_log_code;
`endif
endmodule
